// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg                                                           |
// | Shared types and constants for the 4x4 keypad scan controller.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] KPC_FIRST = 4'b0111;
  localparam logic [3:0] KPR_IDLE  = 4'b1111;

  // Walk the active-low column: 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  function automatic logic [3:0] kpc_next(input logic [3:0] kpc);
    return {kpc[0], kpc[3:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kpdecode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kpdecode                                                             |
// | Maps an active-low column/row pair to a hex key code.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module kpdecode (
  input  logic [3:0] kpc,
  input  logic [3:0] kpr_s,
  output logic       kphit,
  output logic [3:0] num
);

  always_comb begin
    kphit = 1'b1;
    num   = 4'h0;
    case ({kpr_s, kpc})
      {4'b0111, 4'b0111}: num = 4'h1;
      {4'b0111, 4'b1011}: num = 4'h2;
      {4'b0111, 4'b1101}: num = 4'h3;
      {4'b0111, 4'b1110}: num = 4'hA;
      {4'b1011, 4'b0111}: num = 4'h4;
      {4'b1011, 4'b1011}: num = 4'h5;
      {4'b1011, 4'b1101}: num = 4'h6;
      {4'b1011, 4'b1110}: num = 4'hB;
      {4'b1101, 4'b0111}: num = 4'h7;
      {4'b1101, 4'b1011}: num = 4'h8;
      {4'b1101, 4'b1101}: num = 4'h9;
      {4'b1101, 4'b1110}: num = 4'hC;
      {4'b1110, 4'b0111}: num = 4'hE;
      {4'b1110, 4'b1011}: num = 4'h0;
      {4'b1110, 4'b1101}: num = 4'hF;
      {4'b1110, 4'b1110}: num = 4'hD;
      default:            kphit = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_scan_ctrl                                                     |
// | Column scan, row debounce and single-entry key event register.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 50,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic       key_valid,
  output logic [3:0] key_num,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overrun
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  kp_state_t        state_q, state_d;
  logic [3:0]       sync1_q, kpr_s_q;
  logic [3:0]       kpc_q, kpc_d;
  logic [SET_W-1:0] set_cnt_q, set_cnt_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]       cap_row_q, cap_row_d;
  logic [3:0]       cap_num_q, cap_num_d;
  logic             valid_q, valid_d;
  logic [3:0]       num_q, num_d;
  logic             held_q, held_d;
  logic             overrun_q, overrun_d;
  logic             post;
  logic             dec_hit;
  logic [3:0]       dec_num;

  kpdecode u_kpdecode (
    .kpc   (kpc_q),
    .kpr_s (kpr_s_q),
    .kphit (dec_hit),
    .num   (dec_num)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= KPR_IDLE;
      kpr_s_q   <= KPR_IDLE;
      state_q   <= SCAN;
      kpc_q     <= KPC_FIRST;
      set_cnt_q <= '0;
      deb_cnt_q <= '0;
      cap_row_q <= KPR_IDLE;
      cap_num_q <= 4'h0;
      valid_q   <= 1'b0;
      num_q     <= 4'h0;
      held_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= kpr;
      kpr_s_q   <= sync1_q;
      state_q   <= state_d;
      kpc_q     <= kpc_d;
      set_cnt_q <= set_cnt_d;
      deb_cnt_q <= deb_cnt_d;
      cap_row_q <= cap_row_d;
      cap_num_q <= cap_num_d;
      valid_q   <= valid_d;
      num_q     <= num_d;
      held_q    <= held_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kpc_d     = kpc_q;
    set_cnt_d = set_cnt_q;
    deb_cnt_d = deb_cnt_q;
    cap_row_d = cap_row_q;
    cap_num_d = cap_num_q;
    held_d    = held_q;
    post      = 1'b0;

    case (state_q)
      SCAN: begin
        if (set_cnt_q == SET_LAST) begin
          set_cnt_d = '0;
          if (dec_hit) begin
            cap_row_d = kpr_s_q;
            cap_num_d = dec_num;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end else begin
            kpc_d = kpc_next(kpc_q);
          end
        end else begin
          set_cnt_d = set_cnt_q + SET_W'(1);
        end
      end
      DEBOUNCE: begin
        if (kpr_s_q != cap_row_q) begin
          state_d   = SCAN;
          kpc_d     = kpc_next(kpc_q);
          set_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
          held_d    = 1'b1;
          post      = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (kpr_s_q == KPR_IDLE) begin
          state_d   = RELEASE;
          deb_cnt_d = '0;
        end
      end
      RELEASE: begin
        // A row dropping low here is the same key bouncing, not a new press.
        if (kpr_s_q != KPR_IDLE) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = SCAN;
          kpc_d     = kpc_next(kpc_q);
          set_cnt_d = '0;
          deb_cnt_d = '0;
          held_d    = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: begin
        state_d   = SCAN;
        kpc_d     = KPC_FIRST;
        set_cnt_d = '0;
        deb_cnt_d = '0;
        held_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    valid_d   = valid_q;
    num_d     = num_q;
    overrun_d = 1'b0;
    if (post) begin
      if (valid_q && !key_ready) begin
        overrun_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        num_d   = cap_num_q;
      end
    end else if (valid_q && key_ready) begin
      valid_d = 1'b0;
    end
  end

  assign kpc       = kpc_q;
  assign key_valid = valid_q;
  assign key_num   = num_q;
  assign key_held  = held_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_scan_ctrl                                                  |
// | Directed bench for keypad_scan_ctrl with SETTLE=4, DEBOUNCE=8.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_keypad_scan_ctrl;

  localparam logic [3:0] IDLE = 4'b1111;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic       key_valid;
  logic [3:0] key_num;
  logic       key_ready;
  logic       key_held;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] colseq [4];

  typedef struct {
    int         col;
    logic [3:0] row;
    logic [3:0] num;
    int         hold;
  } vec_t;

  vec_t tbl [16];

  keypad_scan_ctrl #(
    .SETTLE_CYCLES   (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .kpr       (kpr),
    .kpc       (kpc),
    .key_valid (key_valid),
    .key_num   (key_num),
    .key_ready (key_ready),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns on the first negedge of a fresh dwell on the requested column.
  task automatic wait_col_start(input logic [3:0] col);
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = kpc;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (kpc == col && prev != col) found = 1;
      prev = kpc;
    end
    check("col_wait", found, 1);
  endtask

  // Drives the row at the start of the column dwell, leaves time at n=11.
  task automatic press_key(input int col, input logic [3:0] row);
    wait_col_start(colseq[col]);
    kpr = row;
    repeat (11) tick();
  endtask

  task automatic release_and_wait();
    bit done;
    done = 0;
    kpr  = IDLE;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!key_held) done = 1;
    end
    check("held_release_wait", done, 1);
  endtask

  initial begin
    int extra;
    int changes;
    int order_err;
    int drops;
    logic [3:0] prev;

    colseq[0] = 4'b0111;
    colseq[1] = 4'b1011;
    colseq[2] = 4'b1101;
    colseq[3] = 4'b1110;

    tbl[0]  = '{0, 4'b0111, 4'h1, 20};
    tbl[1]  = '{0, 4'b1011, 4'h4, 20};
    tbl[2]  = '{0, 4'b1101, 4'h7, 20};
    tbl[3]  = '{0, 4'b1110, 4'hE, 20};
    tbl[4]  = '{1, 4'b0111, 4'h2, 20};
    tbl[5]  = '{1, 4'b1011, 4'h5, 20};
    tbl[6]  = '{1, 4'b1101, 4'h8, 20};
    tbl[7]  = '{1, 4'b1110, 4'h0, 20};
    tbl[8]  = '{2, 4'b0111, 4'h3, 20};
    tbl[9]  = '{2, 4'b1011, 4'h6, 200};
    tbl[10] = '{2, 4'b1101, 4'h9, 20};
    tbl[11] = '{2, 4'b1110, 4'hF, 20};
    tbl[12] = '{3, 4'b0111, 4'hA, 20};
    tbl[13] = '{3, 4'b1011, 4'hB, 20};
    tbl[14] = '{3, 4'b1101, 4'hC, 20};
    tbl[15] = '{3, 4'b1110, 4'hD, 20};

    reset     = 1'b1;
    kpr       = IDLE;
    key_ready = 1'b0;
    repeat (3) tick();
    check("rst_kpc", kpc, 4'b0111);
    check("rst_valid", key_valid, 0);
    check("rst_num", key_num, 0);
    check("rst_held", key_held, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;

    // Every key, consumer always ready.
    key_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      press_key(tbl[i].col, tbl[i].row);
      check("press_latency_valid", key_valid, 0);
      check("press_latency_held", key_held, 0);
      tick();
      check("valid", key_valid, 1);
      check("num", key_num, tbl[i].num);
      check("held", key_held, 1);
      tick();
      check("valid_one_cycle", key_valid, 0);
      extra = 0;
      for (int n = 14; n <= tbl[i].hold; n++) begin
        tick();
        if (key_valid) extra++;
      end
      check("single_event_hold", extra, 0);
      check("held_during_hold", key_held, 1);
      kpr = IDLE;
      repeat (10) tick();
      check("held_before_release", key_held, 1);
      tick();
      check("held_after_release", key_held, 0);
      check("kpc_after_release", kpc, colseq[(tbl[i].col + 1) % 4]);
    end

    // Two presses without acceptance: second is dropped with one overrun pulse.
    key_ready = 1'b0;
    press_key(0, 4'b0111);
    tick();
    check("ovr_first_valid", key_valid, 1);
    check("ovr_first_num", key_num, 4'h1);
    release_and_wait();
    press_key(3, 4'b1110);
    check("ovr_pre", overrun, 0);
    tick();
    check("ovr_pulse", overrun, 1);
    check("ovr_valid_kept", key_valid, 1);
    check("ovr_num_kept", key_num, 4'h1);
    tick();
    check("ovr_pulse_end", overrun, 0);
    release_and_wait();
    check("ovr_num_after", key_num, 4'h1);
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("ready_clears", key_valid, 0);

    // Reset mid-operation with an event pending and a key held.
    press_key(1, 4'b1011);
    tick();
    check("pend_valid", key_valid, 1);
    check("pend_num", key_num, 4'h5);
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_kpc", kpc, 4'b0111);
    check("mid_rst_valid", key_valid, 0);
    check("mid_rst_num", key_num, 0);
    check("mid_rst_held", key_held, 0);
    check("mid_rst_overrun", overrun, 0);
    kpr = IDLE;
    repeat (2) tick();
    reset = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      check("rotate_kpc", kpc, colseq[(n / 4) % 4]);
      tick();
    end

    // Bouncing row: no event until it settles.
    key_ready = 1'b1;
    wait_col_start(colseq[1]);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      kpr = ((i / 3) % 2 == 0) ? 4'b1110 : IDLE;
      tick();
      if (key_valid || key_held) extra++;
    end
    kpr = IDLE;
    repeat (4) tick();
    check("bounce_no_event", extra, 0);
    press_key(1, 4'b1110);
    check("bounce_pre_valid", key_valid, 0);
    tick();
    check("bounce_valid", key_valid, 1);
    check("bounce_num", key_num, 4'h0);
    release_and_wait();

    // Multiple rows low: scanning keeps going, nothing posted.
    kpr       = 4'b0011;
    extra     = 0;
    changes   = 0;
    order_err = 0;
    prev      = kpc;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (key_valid || key_held) extra++;
      if (kpc != prev) begin
        changes++;
        if (kpc != {prev[0], prev[3:1]}) order_err++;
      end
      prev = kpc;
    end
    check("multi_no_event", extra, 0);
    check("multi_col_changes", changes, 10);
    check("multi_col_order", order_err, 0);
    kpr = IDLE;

    // Release glitch: row returns low for 2 cycles inside the release window.
    press_key(2, 4'b1101);
    tick();
    check("glitch_valid", key_valid, 1);
    check("glitch_num", key_num, 4'h9);
    repeat (8) tick();
    kpr = IDLE;
    repeat (5) tick();
    kpr = 4'b1101;
    repeat (2) tick();
    kpr   = IDLE;
    drops = 0;
    extra = 0;
    for (int n = 7; n < 17; n++) begin
      if (!key_held) drops++;
      if (key_valid) extra++;
      tick();
    end
    check("glitch_held_kept", drops, 0);
    check("glitch_no_event", extra, 0);
    check("glitch_held_last", key_held, 1);
    tick();
    check("glitch_held_fall", key_held, 0);
    check("glitch_valid_after", key_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
